mips_data_memory: RTL and testbench
===================================

// Module: mips_data_memory
// PURPOSE
//  Byte-lane data memory that responds to the MIPS core's data port (mem_addr, mem_data_in, mem_write_en, mem_data_out).
//  Reads are combinational so a single-cycle core completes a load in one cycle; writes commit on the clock edge.
//  When the core raises halted, an FSM freezes memory and streams every word out on a ready/valid dump port for bench checking.
// PARAMETERS
//  ADDR_BITS  12  byte-address width; capacity 2**ADDR_BITS bytes, 2**(ADDR_BITS-2) words
// PORTS
//  clk           in   1        clock, rising edge
//  rst_b         in   1        asynchronous reset, active low
//  mem_addr      in   32       byte address from core
//  mem_data_in   in   8x[0:3]  write data from core, lane 0 = lowest address
//  mem_write_en  in   1        write strobe from core
//  mem_data_out  out  8x[0:3]  read data to core, lane 0 = lowest address
//  halted        in   1        core halt indication
//  dump_valid    out  1        dump word present
//  dump_ready    in   1        dump consumer accepts word
//  dump_addr     out  32       byte address of dump word, word-aligned
//  dump_data     out  32       {lane0,lane1,lane2,lane3} (big-endian)
//  dump_done     out  1        all words transferred
//  addr_err      out  1        sticky bad-address flag
// BEHAVIOUR
//  - Reset (rst_b low, async): FSM=IDLE, word counter=0, dump_valid/dump_done/addr_err=0, dump_addr/dump_data=0.
//    Storage contents are NOT reset and survive reset.
//  - Word index = mem_addr[ADDR_BITS-1:2]; mem_addr[1:0] ignored (aligned down).
//  - Read: mem_data_out[i] = mem[{index,2'b00}+i] combinationally, in every state.
//    Out-of-range read (mem_addr[31:ADDR_BITS]!=0) returns the wrapped word, no flag.
//  - Write: in IDLE at posedge with mem_write_en=1, all four lanes written to the word.
//    Read-during-write: mem_data_out shows old data before the edge, new data after it.
//  - Bad write: mem_addr[1:0]!=0 -> write aligned down and committed, addr_err<=1.
//    mem_addr[31:ADDR_BITS]!=0 -> write dropped, addr_err<=1.
//    addr_err is cleared only by reset.
//  - FSM states: IDLE, DUMP, DONE.
//    IDLE -> DUMP on posedge with halted=1; counter<=0.
//      A write with mem_write_en=1 on that same edge IS committed and appears in the dump.
//    DUMP: dump_valid=1, dump_addr={counter,2'b00}, dump_data=word[counter].
//      Transfer at posedge when dump_valid&&dump_ready: counter++.
//      Transfer of last word (counter=2**(ADDR_BITS-2)-1) -> DONE.
//      While dump_ready=0, dump_valid/addr/data hold stable.
//      mem_write_en ignored; halted deasserting does not abort the dump.
//    DONE: dump_valid=0, dump_done=1, writes ignored; exit only via reset.
//  - dump_valid, dump_addr, dump_done decode from registered state/counter (no comb path from dump_ready).
//  - Zero-wait throughput: one word per cycle with dump_ready held high.
//  - Reset mid-dump: immediately IDLE, outputs to reset values; a later halt restarts from word 0.
// TESTING
//  1. Write addr 0x10, lanes {11,22,33,44}, then read 0x10 -> mem_data_out {11,22,33,44}; addr 0x14 unchanged.
//  2. Write 0xAA.. over 0x55.. at 0x20 -> pre-edge read 0x55 lanes, post-edge read 0xAA lanes.
//  3. Misaligned write to 0x13 -> data at word 0x10, addr_err=1.
//     Then write to 0x1000 (ADDR_BITS=12) -> word 0x000 unchanged, addr_err stays 1.
//  4. Preload pattern word[i]=i; assert halted, dump_ready=1 ->
//     1024 beats on consecutive cycles, dump_addr 0x000..0xFFC, dump_data=i, dump_done=1 after the last beat.
//  5. Dump with dump_ready random 50% -> each beat's addr/data stable until accepted; none lost/duplicated.
//  6. Reset at beat 5 of dump -> dump_valid=0 and state IDLE immediately; contents intact;
//     re-halt dumps from dump_addr 0x000.

Source files
------------

// File: rtl/mips_data_memory.sv
// Byte-lane data memory for a single-cycle MIPS core with a post-halt dump streamer.
// Latency: reads are combinational, writes commit at the clock edge; dump emits one word per cycle.
// Backpressure: dump_valid/addr/data hold while dump_ready is low; core writes are ignored once dumping starts.
//
// Ports:
//   clk, rst_b          clock (rising edge), asynchronous active-low reset
//   mem_addr            byte address from core; bits [1:0] ignored for access
//   mem_data_in         write lanes, lane 0 = lowest byte address
//   mem_write_en        write strobe (honoured only in IDLE)
//   mem_data_out        combinational read lanes for the addressed word
//   halted              core halt; starts the dump from IDLE
//   dump_valid/ready    ready/valid handshake for the dump stream
//   dump_addr/data      word-aligned byte address and big-endian word {lane0..lane3}
//   dump_done           every word has been transferred
//   addr_err            sticky flag for misaligned or out-of-range writes
module mips_data_memory #(
  parameter int ADDR_BITS = 12
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [31:0]     mem_addr,
  input  logic [0:3][7:0] mem_data_in,
  input  logic            mem_write_en,
  output logic [0:3][7:0] mem_data_out,
  input  logic            halted,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [31:0]     dump_addr,
  output logic [31:0]     dump_data,
  output logic            dump_done,
  output logic            addr_err
);

  localparam int IW    = ADDR_BITS - 2;
  localparam int WORDS = 2 ** IW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DUMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Storage is deliberately outside the reset domain so contents survive reset.
  logic [0:3][7:0] mem_q [WORDS];

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          addr_err_q, addr_err_d;

  logic [IW-1:0] idx;
  logic          addr_hi_bad;
  logic          wr_fire;
  logic          wr_commit;
  logic          dump_xfer;

  assign idx         = mem_addr[ADDR_BITS-1:2];
  assign addr_hi_bad = |mem_addr[31:ADDR_BITS];

  // Out-of-range reads simply wrap onto the low address bits.
  assign mem_data_out = mem_q[idx];

  assign wr_fire   = (state_q == ST_IDLE) && mem_write_en;
  assign wr_commit = wr_fire && !addr_hi_bad;
  assign dump_xfer = (state_q == ST_DUMP) && dump_ready;

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem_q[idx] <= mem_data_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_err_d = addr_err_q;
    // A misaligned write is still committed (aligned down), but flagged.
    if (wr_fire && (addr_hi_bad || (mem_addr[1:0] != 2'b00))) begin
      addr_err_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (halted) begin
          state_d = ST_DUMP;
          cnt_d   = '0;
        end
      end
      ST_DUMP: begin
        if (dump_xfer) begin
          if (cnt_q == {IW{1'b1}}) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Dump outputs decode from registered state/counter only; memory is frozen
  // outside IDLE so the word read for dump_data is stable during a stall.
  assign dump_valid = (state_q == ST_DUMP);
  assign dump_done  = (state_q == ST_DONE);
  assign dump_addr  = dump_valid ? {{(32-ADDR_BITS){1'b0}}, cnt_q, 2'b00} : 32'd0;
  assign dump_data  = dump_valid ? mem_q[cnt_q] : 32'd0;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_mips_data_memory.sv
module tb_mips_data_memory;

  logic            clk;
  logic            rst_b;
  logic [31:0]     mem_addr;
  logic [0:3][7:0] mem_data_in;
  logic            mem_write_en;
  logic [0:3][7:0] mem_data_out;
  logic            halted;
  logic            dump_valid;
  logic            dump_ready;
  logic [31:0]     dump_addr;
  logic [31:0]     dump_data;
  logic            dump_done;
  logic            addr_err;

  int n_checks = 0;
  int n_errors = 0;

  mips_data_memory #(.ADDR_BITS(12)) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .halted       (halted),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_addr    (dump_addr),
    .dump_data    (dump_data),
    .dump_done    (dump_done),
    .addr_err     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_addr     = a;
    mem_data_in  = d;
    mem_write_en = 1'b1;
    tick();
    mem_write_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a);
    mem_addr = a;
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #3;
    rst_b = 1'b1;
    tick();
  endtask

  initial begin
    int exp_beat;
    int cyc;
    logic rdy;

    rst_b        = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    halted       = 1'b0;
    dump_ready   = 1'b0;
    #12;
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_done",  {31'd0, dump_done},  32'd0);
    chk("rst_err",   {31'd0, addr_err},   32'd0);
    chk("rst_daddr", dump_addr, 32'd0);
    chk("rst_ddata", dump_data, 32'd0);
    rst_b = 1'b1;
    tick();

    // Test 1: basic write/read, neighbour untouched
    wr(32'h14, 32'hDEADBEEF);
    wr(32'h10, 32'h11223344);
    rd(32'h10); chk("t1_rd10", mem_data_out, 32'h11223344);
    rd(32'h14); chk("t1_rd14", mem_data_out, 32'hDEADBEEF);
    chk("t1_noerr", {31'd0, addr_err}, 32'd0);

    // Test 2: read-during-write
    wr(32'h20, 32'h55555555);
    mem_addr = 32'h20; mem_data_in = 32'hAAAAAAAA; mem_write_en = 1'b1;
    #1;
    chk("t2_pre",  mem_data_out, 32'h55555555);
    tick();
    mem_write_en = 1'b0;
    chk("t2_post", mem_data_out, 32'hAAAAAAAA);

    // Test 3: misaligned write aligns down; out-of-range write dropped
    wr(32'h0, 32'h0BADF00D);
    wr(32'h13, 32'h01020304);
    rd(32'h10); chk("t3_mis_data", mem_data_out, 32'h01020304);
    rd(32'h13); chk("t3_mis_rdal", mem_data_out, 32'h01020304);
    chk("t3_mis_err", {31'd0, addr_err}, 32'd1);
    wr(32'h1000, 32'hFFFFFFFF);
    rd(32'h0);    chk("t3_oor_w0",   mem_data_out, 32'h0BADF00D);
    rd(32'h1000); chk("t3_oor_wrap", mem_data_out, 32'h0BADF00D);
    chk("t3_err_sticky", {31'd0, addr_err}, 32'd1);
    do_reset();
    chk("t3_err_clr", {31'd0, addr_err}, 32'd0);
    rd(32'h10); chk("t3_survive", mem_data_out, 32'h01020304);

    // Test 4: preload word[i]=i, last write coincides with halt, full-rate dump
    for (int i = 0; i < 1023; i++) wr(32'(i * 4), 32'(i));
    dump_ready   = 1'b1;
    halted       = 1'b1;
    mem_addr     = 32'hFFC;
    mem_data_in  = 32'd1023;
    mem_write_en = 1'b1;
    tick();
    mem_write_en = 1'b0;
    for (int b = 0; b < 1024; b++) begin
      if (b == 3) halted = 1'b0;
      if (!dump_valid || dump_addr !== 32'(b * 4) || dump_data !== 32'(b)) begin
        chk("t4_valid", {31'd0, dump_valid}, 32'd1);
        chk("t4_addr", dump_addr, 32'(b * 4));
        chk("t4_data", dump_data, 32'(b));
      end else begin
        n_checks++;
      end
      if (b < 1023) chk("t4_notdone", {31'd0, dump_done}, 32'd0);
      tick();
    end
    chk("t4_end_valid", {31'd0, dump_valid}, 32'd0);
    chk("t4_end_done",  {31'd0, dump_done},  32'd1);
    wr(32'h8, 32'h12345678);
    rd(32'h8); chk("t4_done_wr_ignored", mem_data_out, 32'd2);

    // Test 5: random backpressure; writes during dump are ignored
    do_reset();
    chk("t5_rst_done", {31'd0, dump_done}, 32'd0);
    halted = 1'b1;
    dump_ready = 1'b0;
    tick();
    halted = 1'b0;
    mem_addr = 32'h1C; mem_data_in = 32'hFFFFFFFF; mem_write_en = 1'b1;
    exp_beat = 0;
    cyc = 0;
    while (!dump_done && cyc < 6000) begin
      if (dump_valid) begin
        if (dump_addr !== 32'(exp_beat * 4) || dump_data !== 32'(exp_beat)) begin
          chk("t5_addr", dump_addr, 32'(exp_beat * 4));
          chk("t5_data", dump_data, 32'(exp_beat));
        end else begin
          n_checks++;
        end
      end
      rdy = 1'($urandom_range(0, 1));
      dump_ready = rdy;
      if (dump_valid && rdy) exp_beat++;
      tick();
      cyc++;
    end
    mem_write_en = 1'b0;
    chk("t5_beats", 32'(exp_beat), 32'd1024);
    chk("t5_done", {31'd0, dump_done}, 32'd1);
    rd(32'h1C); chk("t5_wr_ignored", mem_data_out, 32'd7);

    // Test 6: reset at beat 5, contents intact, restart from word 0
    do_reset();
    halted = 1'b1;
    dump_ready = 1'b1;
    tick();
    halted = 1'b0;
    for (int b = 0; b < 5; b++) tick();
    chk("t6_beat5_addr", dump_addr, 32'h14);
    rst_b = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("t6_rst_addr", dump_addr, 32'd0);
    chk("t6_rst_data", dump_data, 32'd0);
    chk("t6_rst_done", {31'd0, dump_done}, 32'd0);
    rst_b = 1'b1;
    tick();
    chk("t6_idle_valid", {31'd0, dump_valid}, 32'd0);
    rd(32'h14); chk("t6_intact", mem_data_out, 32'd5);
    halted = 1'b1;
    tick();
    chk("t6_re_valid", {31'd0, dump_valid}, 32'd1);
    chk("t6_re_addr", dump_addr, 32'd0);
    chk("t6_re_data", dump_data, 32'd0);
    tick();
    chk("t6_re_addr1", dump_addr, 32'd4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
